// File: rtl/bcharger_supervisor.sv
// bcharger_supervisor: input conditioning, phase watchdog and fault latch for bcharger.
// Raw comparator flags are synchronised and debounced before reaching bcharger; every
// charge phase is timed against its own limit, and chg_en is dropped on any fault.
// Optional macro BCHG_SUP_TEMP_EN adds a debounced temp_ok input with an over-temp fault.
module bcharger_supervisor #(
    parameter int DEB_CYCLES = 4,
    parameter int TMO_W      = 16,
    parameter int TRKL_TMO   = 1000,
    parameter int FAST_TMO   = 10000,
    parameter int CV_TMO     = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr_fault,
    input  logic       vtrkl_raw,
    input  logic       vterm_raw,
    input  logic       iterm_raw,
    input  logic       vrchrg_raw,
`ifdef BCHG_SUP_TEMP_EN
    input  logic       temp_ok,
`endif
    input  logic       trkl,
    input  logic       fast,
    input  logic       vconst,
    input  logic       done,
    output logic       vtrkl,
    output logic       vterm,
    output logic       iterm,
    output logic       vrchrg,
    output logic       chg_en,
    output logic       fault,
    output logic [2:0] fault_code
);

`ifdef BCHG_SUP_TEMP_EN
    localparam int NF = 5;
`else
    localparam int NF = 4;
`endif

    // Limits must fit in the phase timer or a timeout could never fire.
    if (TRKL_TMO > (2**TMO_W) - 1 || FAST_TMO > (2**TMO_W) - 1 || CV_TMO > (2**TMO_W) - 1) begin : g_lim_err
        $error("bcharger_supervisor: timeout limit wider than TMO_W");
    end

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    logic [NF-1:0]      raw;
    logic [NF-1:0]      s1_q, s1_d, s2_q, s2_d, flt_q, flt_d;
    logic [NF-1:0][7:0] cnt_q, cnt_d;
    logic               temp_good;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   timer_q, timer_d;
    logic [2:0]         phase_q, phase_d;
    logic [2:0]         code_q, code_d;
    logic               ill_q, ill_d;

    logic [2:0]         phase_now;
    logic               multi, active, tmo;
    logic [TMO_W-1:0]   lim;
    logic [2:0]         tmo_code;

`ifdef BCHG_SUP_TEMP_EN
    assign raw       = {temp_ok, vrchrg_raw, iterm_raw, vterm_raw, vtrkl_raw};
    assign temp_good = flt_q[4];
`else
    assign raw       = {vrchrg_raw, iterm_raw, vterm_raw, vtrkl_raw};
    assign temp_good = 1'b1;
`endif

    // Two-flop synchroniser, then a run-length counter: a flag flips only after the
    // synced value has disagreed with it for DEB_CYCLES consecutive cycles.
    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        flt_d = flt_q;
        cnt_d = cnt_q;
        for (int i = 0; i < NF; i++) begin
            if (s2_q[i] == flt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == 8'(DEB_CYCLES - 1)) begin
                flt_d[i] = s2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // Phase decode: the limit applies to the registered phase, and only when exactly
    // one phase flag is set and bcharger is not reporting done.
    always_comb begin
        phase_now = {trkl, fast, vconst};
        multi     = $countones({trkl, fast, vconst, done}) > 1;
        active    = $onehot(phase_q) && !done;
        lim       = phase_q[2] ? TMO_W'(TRKL_TMO) : phase_q[1] ? TMO_W'(FAST_TMO) : TMO_W'(CV_TMO);
        tmo_code  = phase_q[2] ? 3'd1 : phase_q[1] ? 3'd2 : 3'd3;
        tmo       = active && (timer_q == lim);
    end

    // Supervisor FSM and phase timer; fault priority is illegal > over-temp > timeout,
    // and any fault beats en=0 in the same cycle.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        code_d  = code_q;
        phase_d = phase_now;
        ill_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && temp_good) state_d = RUN;
            end
            RUN: begin
                ill_d = multi;
                if (multi && ill_q) begin
                    state_d = FAULT;
                    code_d  = 3'd5;
                end else if (!temp_good) begin
                    state_d = FAULT;
                    code_d  = 3'd4;
                end else if (tmo) begin
                    state_d = FAULT;
                    code_d  = tmo_code;
                end else if (!en) begin
                    state_d = IDLE;
                end else if (phase_now == phase_q && active) begin
                    timer_d = (timer_q == '1) ? timer_q : timer_q + TMO_W'(1);
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    state_d = IDLE;
                    code_d  = 3'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            flt_q   <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            timer_q <= '0;
            phase_q <= '0;
            code_q  <= '0;
            ill_q   <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            flt_q   <= flt_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            timer_q <= timer_d;
            phase_q <= phase_d;
            code_q  <= code_d;
            ill_q   <= ill_d;
        end
    end

    assign {vrchrg, iterm, vterm, vtrkl} = flt_q[3:0];
    assign chg_en     = (state_q == RUN);
    assign fault      = (state_q == FAULT);
    assign fault_code = code_q;

endmodule

// File: tb/tb_bcharger_supervisor.sv
// Directed + randomized bench for bcharger_supervisor against a cycle-count reference model.
module tb_bcharger_supervisor;

    localparam int DEB = 4;
    localparam int LIM_TRKL = 20;
    localparam int LIM_FAST = 40;
    localparam int LIM_CV   = 30;
`ifdef BCHG_SUP_TEMP_EN
    localparam bit TEMP = 1'b1;
`else
    localparam bit TEMP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, en, clr_fault;
    logic vtrkl_raw, vterm_raw, iterm_raw, vrchrg_raw, temp_ok;
    logic trkl, fast, vconst, done;
    logic vtrkl, vterm, iterm, vrchrg, chg_en, fault;
    logic [2:0] fault_code;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcharger_supervisor #(
        .DEB_CYCLES(DEB), .TMO_W(16),
        .TRKL_TMO(LIM_TRKL), .FAST_TMO(LIM_FAST), .CV_TMO(LIM_CV)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .clr_fault(clr_fault),
        .vtrkl_raw(vtrkl_raw), .vterm_raw(vterm_raw), .iterm_raw(iterm_raw), .vrchrg_raw(vrchrg_raw),
`ifdef BCHG_SUP_TEMP_EN
        .temp_ok(temp_ok),
`endif
        .trkl(trkl), .fast(fast), .vconst(vconst), .done(done),
        .vtrkl(vtrkl), .vterm(vterm), .iterm(iterm), .vrchrg(vrchrg),
        .chg_en(chg_en), .fault(fault), .fault_code(fault_code)
    );

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 charging, 2 faulted
    int         m_mode;
    logic [2:0] m_code;
    logic [4:0] m_filt;
    int         m_age;        // cycles the current phase has been stable while charging
    logic [2:0] m_ph;         // phase seen at the previous edge
    bit         m_multi_prev; // overlap seen at the previous charging edge
    logic [4:0] rq[$];        // raw samples at the last DEB+2 edges, oldest first

    task automatic model_reset();
        m_mode = 0; m_code = 3'd0; m_filt = 5'd0; m_age = 0; m_ph = 3'd0; m_multi_prev = 0;
        rq.delete();
        for (int i = 0; i < DEB + 2; i++) rq.push_back(5'd0);
    endtask

    task automatic model_edge();
        logic [4:0] nf;
        logic [2:0] cur;
        int nflags, limit, nmode, nage;
        bit one_ph, temp_good, differs;
        logic [2:0] ncode;
        rq.push_back({temp_ok, vrchrg_raw, iterm_raw, vterm_raw, vtrkl_raw});
        if (rq.size() > DEB + 2) void'(rq.pop_front());
        // a flag flips once the synced input (raw two edges back) disagreed for DEB edges
        nf = m_filt;
        for (int b = 0; b < 5; b++) begin
            differs = 1;
            for (int k = 0; k < DEB; k++) if (rq[k][b] == m_filt[b]) differs = 0;
            if (differs) nf[b] = ~m_filt[b];
        end
        cur       = {trkl, fast, vconst};
        nflags    = int'(trkl) + int'(fast) + int'(vconst) + int'(done);
        one_ph    = (m_ph == 3'b100 || m_ph == 3'b010 || m_ph == 3'b001) && !done;
        limit     = (m_ph == 3'b100) ? LIM_TRKL : (m_ph == 3'b010) ? LIM_FAST : LIM_CV;
        temp_good = !TEMP || m_filt[4];
        nmode = m_mode; ncode = m_code; nage = 0;
        if (m_mode == 0) begin
            if (en && temp_good) nmode = 1;
        end else if (m_mode == 1) begin
            if (nflags > 1 && m_multi_prev) begin nmode = 2; ncode = 3'd5; end
            else if (!temp_good) begin nmode = 2; ncode = 3'd4; end
            else if (one_ph && m_age == limit) begin
                nmode = 2;
                ncode = (m_ph == 3'b100) ? 3'd1 : (m_ph == 3'b010) ? 3'd2 : 3'd3;
            end
            else if (!en) nmode = 0;
            else if (cur == m_ph && one_ph) nage = (m_age >= 65535) ? 65535 : m_age + 1;
        end else begin
            if (clr_fault) begin nmode = 0; ncode = 3'd0; end
        end
        m_multi_prev = (m_mode == 1) && (nflags > 1);
        m_mode = nmode; m_code = ncode; m_age = nage; m_ph = cur; m_filt = nf;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, "_flags"}, {4'b0, vrchrg, iterm, vterm, vtrkl}, {4'b0, m_filt[3:0]});
        chk({tag, "_ctl"}, {3'b0, chg_en, fault, fault_code},
            {3'b0, m_mode == 1, m_mode == 2, m_code});
    endtask

    // one clock: model follows the active edge, outputs compared on the falling edge
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outs(tag);
    endtask

    int lat;
    int rem;
    int sel;

    initial begin
        reset = 1'b0; en = 1'b0; clr_fault = 1'b0;
        vtrkl_raw = 1'b0; vterm_raw = 1'b0; iterm_raw = 1'b0; vrchrg_raw = 1'b0; temp_ok = 1'b1;
        trkl = 1'b0; fast = 1'b0; vconst = 1'b0; done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outs("reset");
        reset = 1'b1;

        // 1. debounce: short glitch filtered, held edge appears after 2+DEB cycles
        vterm_raw = 1'b1;
        repeat (3) cyc("glitch_hi");
        vterm_raw = 1'b0;
        repeat (8) begin
            cyc("glitch_lo");
            chk("glitch_vterm", {7'b0, vterm}, 8'd0);
        end
        vterm_raw = 1'b1;
        lat = 0;
        while (lat < 20) begin
            cyc("deb");
            lat++;
            if (vterm) break;
        end
        chk("deb_latency", 8'(lat), 8'(2 + DEB));

        // 2. normal charge walk
        trkl = 1'b1; en = 1'b1;
        repeat (10) cyc("n_trkl");
        trkl = 1'b0; fast = 1'b1;
        repeat (30) cyc("n_fast");
        fast = 1'b0; vconst = 1'b1;
        repeat (25) cyc("n_cv");
        vconst = 1'b0; done = 1'b1;
        repeat (10) cyc("n_done");
        chk("normal_state", {6'b0, chg_en, fault}, 8'b10);
        en = 1'b0; done = 1'b0;
        repeat (2) cyc("n_stop");
        chk("normal_stop", {7'b0, chg_en}, 8'd0);

        // 3. trickle timeout, clear, restart
        trkl = 1'b1;
        cyc("t_pre");
        en = 1'b1;
        lat = 0;
        while (lat < 60) begin
            cyc("tmo");
            lat++;
            if (fault) break;
        end
        chk("tmo_latency", 8'(lat), 8'(LIM_TRKL + 2));
        chk("tmo_code", {5'b0, fault_code}, 8'd1);
        chk("tmo_chg_en", {7'b0, chg_en}, 8'd0);
        clr_fault = 1'b1;
        cyc("t_clr");
        clr_fault = 1'b0;
        chk("clr_to_idle", {6'b0, chg_en, fault}, 8'd0);
        cyc("t_rerun");
        chk("rerun", {7'b0, chg_en}, 8'd1);

        // 4. illegal overlap
        trkl = 1'b0; fast = 1'b1; vconst = 1'b1;
        repeat (2) cyc("ill");
        chk("ill_code", {5'b0, fault_code}, 8'd5);
        fast = 1'b0; vconst = 1'b0; clr_fault = 1'b1;
        cyc("ill_clr");
        clr_fault = 1'b0;
        cyc("ill_rerun");
`ifdef BCHG_SUP_TEMP_EN
        // illegal coinciding with over-temp: illegal wins
        temp_ok = 1'b0;
        repeat (5) cyc("prio_pre");
        fast = 1'b1; vconst = 1'b1;
        repeat (2) cyc("prio");
        chk("prio_code", {5'b0, fault_code}, 8'd5);
        fast = 1'b0; vconst = 1'b0; temp_ok = 1'b1; clr_fault = 1'b1;
        cyc("prio_clr");
        clr_fault = 1'b0;
        repeat (8) cyc("prio_settle");
`endif

        // 5. asynchronous reset mid fast phase (timer at 35)
        fast = 1'b1;
        repeat (36) cyc("r_fast");
        #2 reset = 1'b0;
        #1;
        chk("arst_outs", {3'b0, chg_en, fault, fault_code}, 8'd0);
        chk("arst_flags", {4'b0, vrchrg, iterm, vterm, vtrkl}, 8'd0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lat = 0;
        while (lat < 80) begin
            cyc("r_resume");
            lat++;
            if (fault) break;
        end
        chk("resume_latency", 8'(lat), 8'(LIM_FAST + 2));
        chk("resume_code", {5'b0, fault_code}, 8'd2);
        fast = 1'b0; clr_fault = 1'b1;
        cyc("r_clr");
        clr_fault = 1'b0;

`ifdef BCHG_SUP_TEMP_EN
        // 6. over-temp during RUN
        repeat (8) cyc("ot_pre");
        temp_ok = 1'b0;
        repeat (8) cyc("ot");
        chk("ot_code", {5'b0, fault_code}, 8'd4);
        temp_ok = 1'b1; clr_fault = 1'b1;
        cyc("ot_clr");
        clr_fault = 1'b0;
`endif

        // randomized traffic against the model
        rem = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) vtrkl_raw  = ~vtrkl_raw;
            if ($urandom_range(0, 5) == 0) vterm_raw  = ~vterm_raw;
            if ($urandom_range(0, 5) == 0) iterm_raw  = ~iterm_raw;
            if ($urandom_range(0, 5) == 0) vrchrg_raw = ~vrchrg_raw;
            if (TEMP && $urandom_range(0, 60) == 0) temp_ok = ~temp_ok;
            if ($urandom_range(0, 50) == 0) en = ~en;
            clr_fault = ($urandom_range(0, 12) == 0);
            if (rem == 0) begin
                sel = $urandom_range(0, 9);
                {trkl, fast, vconst, done} =
                    (sel <= 2) ? 4'b1000 : (sel <= 4) ? 4'b0100 : (sel <= 6) ? 4'b0010 :
                    (sel == 7) ? 4'b0001 : (sel == 8) ? 4'b0000 : 4'($urandom_range(0, 15));
                rem = $urandom_range(1, 45);
            end else begin
                rem--;
            end
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
